hdu_ingress_scheduler: RTL and testbench
========================================

// Module: hdu_ingress_scheduler
// PURPOSE
//  Shares the single header-parse datapath between NUM_PORTS ingress requesters. Per cycle it picks at most one
//  port round-robin, registers that port's header word onto the parser input, and tracks the source port.
//  The parser cannot stall and has fixed latency, so the source port comes out beside the parsed func_id/token.
//  The parser has no backpressure, so issue is gated by downstream dispatch-queue credits. Drain control
//  quiesces the path for function reconfiguration.
// PARAMETERS
//  NUM_PORTS  4                    number of ingress requesters (>=2)
//  DATA_W     `HDU_DATA_WIDTH      header word width
//  PARSER_LAT 1                    parser latency in cycles, input valid to output valid (>=1)
//  CREDITS    8                    dispatch-queue depth; initial and maximum credit count
//  PORT_W     $clog2(NUM_PORTS)    source-port tag width (derived)
//  CRED_W     $clog2(CREDITS+1)    credit counter width (derived)
// PORTS
//  clk            in   1                  sole clock
//  rst            in   1                  synchronous, active-high reset
//  req_valid      in   NUM_PORTS          per-port header word valid
//  req_data       in   NUM_PORTS*DATA_W   per-port header words; port i at [i*DATA_W +: DATA_W]
//  req_ready      out  NUM_PORTS          one-hot grant; word i is accepted when req_valid[i] & req_ready[i]
//  hp_in_valid    out  1                  to parser in_valid
//  hp_in_data     out  DATA_W             to parser in_data
//  tag_valid      out  1                  high in the same cycle as parser out_valid
//  tag_port       out  PORT_W             source port of the parser output in that cycle
//  credit_return  in   1                  downstream freed one queue entry (1-cycle pulse)
//  drain_req      in   1                  level; request quiesce
//  drain_ack      out  1                  level; no grants and no words in flight
//  credits_avail  out  CRED_W             current credit count
//  err_credit_ovf out  1                  sticky; credit_return arrived while credits were already at CREDITS
// BEHAVIOUR
//  Reset values:
//   - req_ready=0, hp_in_valid=0, hp_in_data=0, tag_valid=0, tag_port=0, drain_ack=0, err_credit_ovf=0.
//   - credits_avail=CREDITS, rr_ptr=NUM_PORTS-1 so port 0 has first priority, FSM=RUN.
//  FSM:
//   - RUN: grants allowed. Goes to DRAIN when drain_req=1.
//   - DRAIN: no grants. Goes to QUIESCED when tag pipeline and hp_in_valid are both empty.
//   - QUIESCED: drain_ack=1. Goes to RUN when drain_req=0; drain_ack drops that same transition.
//   - If drain_req falls while in DRAIN, return to RUN directly.
//  Grant:
//   - req_ready is combinational from registered state and req_valid, and is one-hot or zero.
//   - Grant only when state==RUN and credits_avail>0.
//   - Winner is the first valid port scanning from rr_ptr+1 modulo NUM_PORTS.
//   - On a fire, rr_ptr becomes the winner. With no fire, rr_ptr holds.
//  Issue:
//   - On a fire at cycle t, hp_in_valid=1 and hp_in_data=the winning word at t+1.
//   - With no fire, hp_in_valid=0 and hp_in_data holds its last value.
//  Tag:
//   - A shift register of depth PARSER_LAT+1 carries {fire, winner}.
//   - tag_valid/tag_port for a word accepted at t appear at t+1+PARSER_LAT, aligned with the parser output.
//  Credits:
//   - A fire decrements, credit_return increments; both in one cycle leave the count unchanged.
//   - A return in cycle t does not enable a grant in cycle t; the grant check uses the registered count.
//   - A return at CREDITS with no fire: count saturates and err_credit_ovf sets; it clears only on rst.
//   - The count never underflows, because grant requires credits_avail>0.
//  Throughput: one word per cycle while credits last; no bubbles between back-to-back grants.
//  Reset mid-operation:
//   - All in-flight tags are dropped and credits return to CREDITS.
//   - The parser and dispatch queue must be reset in the same cycle; the system guarantees this.
// STRUCTURE
//  hdu_pkg holds:
//   - the HDU_* width constants (DATA/FUNC/TOKEN widths and field positions), now also used by this block;
//   - typedef enum logic [1:0] {SCH_RUN, SCH_DRAIN, SCH_QUIESCED} hdu_sched_state_e.
//  Sub-module hdu_rr_arbiter (NUM_PORTS): request vector, enable and pointer in; one-hot grant and index out;
//  purely combinational. The parent owns rr_ptr, credits, FSM and the tag pipeline.
// TESTING
//  1. Reset, then all 4 ports valid and held for 8 cycles (CREDITS=8):
//     grants 0,1,2,3,0,1,2,3; tag_port shows the same sequence 2 cycles after each grant (PARSER_LAT=1).
//  2. Only port 2 valid, continuously: it is granted every cycle until credits reach 0; req_ready then stays 0.
//     One credit_return pulse yields exactly one further grant, on the following cycle.
//  3. credits_avail=3; in one cycle a fire and a credit_return together: count stays 3; err_credit_ovf stays 0.
//  4. credits_avail=CREDITS and a credit_return with no fire: count stays at CREDITS; err_credit_ovf rises
//     next cycle and stays high until rst.
//  5. drain_req raised with 2 words in flight: no new grants, drain_ack=1 once both tags have emerged.
//     drain_req dropped: drain_ack=0 and grants resume next cycle from rr_ptr+1.
//  6. rst asserted one cycle after a grant: tag_valid never fires for that word; credits_avail=CREDITS;
//     after release, port 0 wins first.

Source files
------------

// File: rtl/hdu_pkg.sv
// Shared header-datapath-unit constants and types: header word layout and
// the ingress scheduler state encoding.
package hdu_pkg;

   localparam int HDU_DATA_WIDTH  = 32;
   localparam int HDU_FUNC_WIDTH  = 8;
   localparam int HDU_TOKEN_WIDTH = 16;
   localparam int HDU_FUNC_LSB    = 24;
   localparam int HDU_TOKEN_LSB   = 0;

   typedef enum logic [1:0] {
      SCH_RUN,
      SCH_DRAIN,
      SCH_QUIESCED
   } hdu_sched_state_e;

endpackage

// File: rtl/hdu_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr_i (mod NUM_PORTS)
// wins when en_i is high. The caller owns and advances the pointer.
module hdu_rr_arbiter
   import hdu_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int PORT_W    = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic                 en_i,
   input  logic [PORT_W-1:0]    ptr_i,
   output logic [NUM_PORTS-1:0] gnt_o,
   output logic [PORT_W-1:0]    gnt_idx_o
);

   logic found;
   int   cand;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      cand      = 0;
      // Scan starts one past the last winner so the previous winner has lowest priority.
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand = (int'(ptr_i) + k) % NUM_PORTS;
         if (en_i && !found && req_i[cand]) begin
            found           = 1'b1;
            gnt_o[cand]     = 1'b1;
            gnt_idx_o       = PORT_W'(cand);
         end
      end
   end

endmodule

// File: rtl/hdu_ingress_scheduler.sv
// Round-robin ingress scheduler in front of the fixed-latency header parser:
// credit-gated issue, source-port tag pipeline aligned to the parser output, drain control.
module hdu_ingress_scheduler
   import hdu_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_W     = HDU_DATA_WIDTH,
   parameter int PARSER_LAT = 1,
   parameter int CREDITS    = 8,
   parameter int PORT_W     = $clog2(NUM_PORTS),
   parameter int CRED_W     = $clog2(CREDITS + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        req_valid,
   input  logic [NUM_PORTS*DATA_W-1:0] req_data,
   output logic [NUM_PORTS-1:0]        req_ready,
   output logic                        hp_in_valid,
   output logic [DATA_W-1:0]           hp_in_data,
   output logic                        tag_valid,
   output logic [PORT_W-1:0]           tag_port,
   input  logic                        credit_return,
   input  logic                        drain_req,
   output logic                        drain_ack,
   output logic [CRED_W-1:0]           credits_avail,
   output logic                        err_credit_ovf,
   output hdu_sched_state_e            dbg_state
);

   // Handshake: word i transfers in a cycle where req_valid[i] & req_ready[i];
   // req_ready depends on req_valid but never the reverse, and is one-hot or zero.

   hdu_sched_state_e   state_q, state_d;
   logic [PORT_W-1:0]  rr_ptr_q;
   logic [CRED_W-1:0]  credits_q, credits_d;
   logic               err_q, err_d;
   logic               hp_valid_q;
   logic [DATA_W-1:0]  hp_data_q;
   logic [PARSER_LAT:0] tag_v_q;
   logic [PORT_W-1:0]  tag_p_q [PARSER_LAT+1];

   logic               grant_en;
   logic [NUM_PORTS-1:0] gnt;
   logic [PORT_W-1:0]  win_idx;
   logic               fire;
   logic [DATA_W-1:0]  win_data;

   assign grant_en = (state_q == SCH_RUN) && (credits_q != '0);

   hdu_rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .PORT_W    (PORT_W)
   ) u_arb (
      .req_i     (req_valid),
      .en_i      (grant_en),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (win_idx)
   );

   assign fire     = |gnt;
   assign win_data = req_data[int'(win_idx)*DATA_W +: DATA_W];

   always_comb begin
      credits_d = credits_q;
      err_d     = err_q;
      unique case ({fire, credit_return})
         2'b10: credits_d = credits_q - CRED_W'(1);
         2'b01: begin
            if (credits_q == CRED_W'(CREDITS)) err_d = 1'b1;
            else                                credits_d = credits_q + CRED_W'(1);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SCH_RUN: if (drain_req) state_d = SCH_DRAIN;
         SCH_DRAIN: begin
            if (!drain_req)                         state_d = SCH_RUN;
            else if (!hp_valid_q && tag_v_q == '0)  state_d = SCH_QUIESCED;
         end
         SCH_QUIESCED: if (!drain_req) state_d = SCH_RUN;
         default: state_d = SCH_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= SCH_RUN;
         rr_ptr_q   <= PORT_W'(NUM_PORTS - 1);
         credits_q  <= CRED_W'(CREDITS);
         err_q      <= 1'b0;
         hp_valid_q <= 1'b0;
         hp_data_q  <= '0;
         tag_v_q    <= '0;
         for (int i = 0; i <= PARSER_LAT; i++) tag_p_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         credits_q  <= credits_d;
         err_q      <= err_d;
         hp_valid_q <= fire;
         if (fire) begin
            rr_ptr_q  <= win_idx;
            hp_data_q <= win_data;
         end
         // Stage 0 mirrors the parser input register; the last stage lines up with parser out_valid.
         tag_v_q    <= {tag_v_q[PARSER_LAT-1:0], fire};
         tag_p_q[0] <= win_idx;
         for (int i = 1; i <= PARSER_LAT; i++) tag_p_q[i] <= tag_p_q[i-1];
      end
   end

   assign req_ready      = gnt;
   assign hp_in_valid    = hp_valid_q;
   assign hp_in_data     = hp_data_q;
   assign tag_valid      = tag_v_q[PARSER_LAT];
   assign tag_port       = tag_p_q[PARSER_LAT];
   assign drain_ack      = (state_q == SCH_QUIESCED);
   assign credits_avail  = credits_q;
   assign err_credit_ovf = err_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_hdu_ingress_scheduler.sv
// Directed bench for hdu_ingress_scheduler: expected grants are queued by the
// stimulus, a negedge monitor checks grants, parser-input words and tag timing.
module tb_hdu_ingress_scheduler;
   import hdu_pkg::*;

   localparam int NP   = 4;
   localparam int W    = HDU_DATA_WIDTH;
   localparam int LAT  = 1;
   localparam int CRED = 8;

   logic              clk;
   logic              rst;
   logic [NP-1:0]     req_valid;
   logic [NP*W-1:0]   req_data;
   logic [NP-1:0]     req_ready;
   logic              hp_in_valid;
   logic [W-1:0]      hp_in_data;
   logic              tag_valid;
   logic [1:0]        tag_port;
   logic              credit_return;
   logic              drain_req;
   logic              drain_ack;
   logic [3:0]        credits_avail;
   logic              err_credit_ovf;
   hdu_sched_state_e  dbg_state;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [1:0]   exp_grant_q[$];
   bit           exp_has_tag_q[$];
   logic [W-1:0] exp_q[$];
   logic [1:0]   exp_tag_q[$];
   int           due_q[$];

   hdu_ingress_scheduler #(
      .NUM_PORTS (NP), .DATA_W (W), .PARSER_LAT (LAT), .CREDITS (CRED)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_data       (req_data),
      .req_ready      (req_ready),
      .hp_in_valid    (hp_in_valid),
      .hp_in_data     (hp_in_data),
      .tag_valid      (tag_valid),
      .tag_port       (tag_port),
      .credit_return  (credit_return),
      .drain_req      (drain_req),
      .drain_ack      (drain_ack),
      .credits_avail  (credits_avail),
      .err_credit_ovf (err_credit_ovf),
      .dbg_state      (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_unexpected(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got 0x%0h, required nothing (cycle %0d)", name, act, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_grant(input int p, input bit has_tag);
      exp_grant_q.push_back(2'(p));
      exp_has_tag_q.push_back(has_tag);
   endtask

   task automatic set_data(input int test_id);
      for (int i = 0; i < NP; i++)
         req_data[i*W +: W] = 32'hA000_0000 + 32'(i) * 32'h0000_0111 + 32'(test_id) * 32'h0001_0000;
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [1:0]    mon_p;
   logic [NP-1:0] mon_oh;
   bit            mon_t;

   always @(negedge clk) begin
      if (hp_in_valid === 1'b1) begin
         if (exp_q.size() == 0) fail_unexpected("hp_in_valid", hp_in_data);
         else chk("hp_in_data", hp_in_data, exp_q.pop_front());
      end
      if (req_ready !== '0) begin
         if (exp_grant_q.size() == 0) fail_unexpected("req_ready", 32'(req_ready));
         else begin
            mon_p  = exp_grant_q.pop_front();
            mon_t  = exp_has_tag_q.pop_front();
            mon_oh = '0;
            mon_oh[mon_p] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(mon_oh));
            exp_q.push_back(req_data[mon_p*W +: W]);
            if (mon_t) begin
               exp_tag_q.push_back(mon_p);
               due_q.push_back(cyc + 1 + LAT);
            end
         end
      end
      if (tag_valid === 1'b1) begin
         if (exp_tag_q.size() == 0) fail_unexpected("tag_valid", 32'(tag_port));
         else begin
            chk("tag_port", 32'(tag_port), 32'(exp_tag_q.pop_front()));
            chk("tag_cycle", 32'(cyc), 32'(due_q.pop_front()));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; req_valid = '0; req_data = '0; credit_return = 1'b0; drain_req = 1'b0;
      set_data(0);
      repeat (3) tick();
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_hp_in_valid", 32'(hp_in_valid), 0);
      chk("rst_hp_in_data", hp_in_data, 0);
      chk("rst_tag_valid", 32'(tag_valid), 0);
      chk("rst_tag_port", 32'(tag_port), 0);
      chk("rst_drain_ack", 32'(drain_ack), 0);
      chk("rst_err_ovf", 32'(err_credit_ovf), 0);
      chk("rst_credits", 32'(credits_avail), CRED);
      rst = 1'b0;

      // 1: all ports valid, rotation 0,1,2,3,0,1,2,3 until credits run out
      for (int k = 0; k < 8; k++) expect_grant(k % 4, 1'b1);
      req_valid = 4'hF;
      repeat (8) tick();
      chk("t1_credits_zero", 32'(credits_avail), 0);
      chk("t1_ready_blocked", 32'(req_ready), 0);
      req_valid = '0;
      repeat (3) tick();

      // 2: restore credits, single requester drains them, one return gives one grant
      credit_return = 1'b1;
      repeat (8) tick();
      credit_return = 1'b0;
      chk("t2_credits_full", 32'(credits_avail), CRED);
      set_data(1);
      for (int k = 0; k < 8; k++) expect_grant(2, 1'b1);
      req_valid = 4'b0100;
      repeat (8) tick();
      chk("t2_ready_zero_a", 32'(req_ready), 0);
      tick();
      chk("t2_ready_zero_b", 32'(req_ready), 0);
      expect_grant(2, 1'b1);
      credit_return = 1'b1;
      chk("t2_ret_no_same_cycle", 32'(req_ready), 0);
      tick();
      credit_return = 1'b0;
      chk("t2_regrant", 32'(req_ready), 32'h4);
      chk("t2_credits_one", 32'(credits_avail), 1);
      tick();
      chk("t2_ready_after", 32'(req_ready), 0);
      chk("t2_credits_back0", 32'(credits_avail), 0);
      req_valid = '0;
      repeat (3) tick();

      // 3: fire and return in the same cycle at credits=3
      credit_return = 1'b1;
      repeat (3) tick();
      credit_return = 1'b0;
      chk("t3_credits_3", 32'(credits_avail), 3);
      set_data(2);
      expect_grant(1, 1'b1);
      req_valid = 4'b0010;
      credit_return = 1'b1;
      tick();
      req_valid = '0;
      credit_return = 1'b0;
      chk("t3_credits_hold", 32'(credits_avail), 3);
      chk("t3_err_clear", 32'(err_credit_ovf), 0);
      repeat (3) tick();

      // 4: return at full credits saturates and sets the sticky error
      credit_return = 1'b1;
      repeat (5) tick();
      credit_return = 1'b0;
      chk("t4_credits_full", 32'(credits_avail), CRED);
      chk("t4_err_before", 32'(err_credit_ovf), 0);
      credit_return = 1'b1;
      tick();
      credit_return = 1'b0;
      chk("t4_credits_sat", 32'(credits_avail), CRED);
      chk("t4_err_set", 32'(err_credit_ovf), 1);
      repeat (3) tick();
      chk("t4_err_sticky", 32'(err_credit_ovf), 1);

      // 5: drain with two words in flight, then resume from rr_ptr+1
      set_data(3);
      expect_grant(2, 1'b1);
      expect_grant(3, 1'b1);
      req_valid = 4'b1100;
      tick();
      req_valid = 4'hF;
      drain_req = 1'b1;
      tick();
      for (int i = 0; i < 10 && drain_ack !== 1'b1; i++) begin
         chk("t5_no_grant", 32'(req_ready), 0);
         tick();
      end
      chk("t5_drain_ack", 32'(drain_ack), 1);
      chk("t5_tags_out", 32'(exp_tag_q.size()), 0);
      chk("t5_quiesced_ready", 32'(req_ready), 0);
      expect_grant(0, 1'b1);
      drain_req = 1'b0;
      tick();
      chk("t5_ack_drop", 32'(drain_ack), 0);
      chk("t5_resume", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      repeat (4) tick();

      // 6: reset one cycle after a grant drops its tag and restores credits
      set_data(4);
      expect_grant(1, 1'b0);
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_credits", 32'(credits_avail), CRED);
      chk("t6_err_cleared", 32'(err_credit_ovf), 0);
      chk("t6_tag_valid", 32'(tag_valid), 0);
      chk("t6_hp_valid", 32'(hp_in_valid), 0);
      repeat (3) tick();
      expect_grant(0, 1'b1);
      req_valid = 4'b0011;
      tick();
      req_valid = '0;
      repeat (4) tick();

      chk("end_grant_q_empty", 32'(exp_grant_q.size()), 0);
      chk("end_data_q_empty", 32'(exp_q.size()), 0);
      chk("end_tag_q_empty", 32'(exp_tag_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
